tetris_field_logic: RTL and testbench



---
 rtl/tetris_field_logic.sv | 227 ++++++++++++++++++++++
 tb/tb_tetris_field_logic.sv | 269 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/tetris_field_logic.sv
// Playfield logic: combinational fit check and merge, plus a sequential row-clear engine.
// Optional feature macro: FIELD_SPAWN_ABOVE_EN (cells above row 0 pass the fit check).

`ifndef FIELD_HORIZONTAL
`define FIELD_HORIZONTAL 10
`endif
`ifndef FIELD_VERTICAL
`define FIELD_VERTICAL 22
`endif

package tetris_pkg;
    localparam int COORD_W = 8;

    localparam logic [2:0] TETROMINO_I_IDX = 3'd0;
    localparam logic [2:0] TETROMINO_O_IDX = 3'd1;
    localparam logic [2:0] TETROMINO_T_IDX = 3'd2;
    localparam logic [2:0] TETROMINO_S_IDX = 3'd3;
    localparam logic [2:0] TETROMINO_Z_IDX = 3'd4;
    localparam logic [2:0] TETROMINO_J_IDX = 3'd5;
    localparam logic [2:0] TETROMINO_L_IDX = 3'd6;
    localparam logic [2:0] EMPTY_IDX       = 3'd7;

    typedef struct packed {
        logic [3:0][15:0] data;
    } tetromino_t;

    typedef struct packed {
        logic signed [COORD_W-1:0] x;
        logic signed [COORD_W-1:0] y;
    } coord_t;

    typedef struct packed {
        logic [2:0] idx;
        tetromino_t tetromino;
        logic [1:0] rotation;
        coord_t     coordinate;
    } tetromino_ctrl;
endpackage

module tetris_field_logic
    import tetris_pkg::*;
#(
    parameter int FIELD_W = `FIELD_HORIZONTAL,
    parameter int FIELD_H = `FIELD_VERTICAL,
    parameter int CELL_W  = 3
) (
    input  logic                                       clk,
    input  logic                                       rst,
    input  tetromino_ctrl                              chk_t,
    input  logic [FIELD_H-1:0][FIELD_W-1:0][CELL_W-1:0] chk_f,
    output logic                                       is_valid,
    input  tetromino_ctrl                              mrg_t,
    input  logic [FIELD_H-1:0][FIELD_W-1:0][CELL_W-1:0] mrg_f,
    output logic [FIELD_H-1:0][FIELD_W-1:0][CELL_W-1:0] mrg_f_out,
    input  logic                                       clean_enable,
    input  logic [FIELD_H-1:0][FIELD_W-1:0][CELL_W-1:0] clean_f_in,
    output logic [FIELD_H-1:0][FIELD_W-1:0][CELL_W-1:0] clean_f_out,
    output logic [2:0]                                 lines_cleared,
    output logic                                       clean_done
);

    localparam int RW = $clog2(FIELD_H);
    localparam int XW = $clog2(FIELD_W);
    localparam int CW = COORD_W + 2;
    localparam logic signed [CW-1:0] H_S = CW'(FIELD_H);
    localparam logic signed [CW-1:0] W_S = CW'(FIELD_W);

    typedef logic [FIELD_H-1:0][FIELD_W-1:0][CELL_W-1:0] field_t;
    typedef logic [FIELD_W-1:0][CELL_W-1:0]              row_t;

    function automatic logic signed [CW-1:0] sext(input logic [COORD_W-1:0] v);
        return $signed({{(CW-COORD_W){v[COORD_W-1]}}, v});
    endfunction

    logic [15:0]          w_chk_mask;
    logic [15:0]          w_mrg_mask;
    logic [15:0]          w_chk_bad;
    logic [15:0]          w_mrg_hit;
    logic [15:0][RW-1:0]  w_mrg_row;
    logic [15:0][XW-1:0]  w_mrg_col;
    logic                 w_idx_seen;

    assign w_chk_mask = chk_t.tetromino.data[chk_t.rotation];
    assign w_mrg_mask = mrg_t.tetromino.data[mrg_t.rotation];

    // Cell gi of the 4x4 piece box sits at piece row gi/4, column gi%4.
    for (genvar gi = 0; gi < 16; gi++) begin : g_cell
        localparam logic signed [CW-1:0] PR = CW'(gi / 4);
        localparam logic signed [CW-1:0] PC = CW'(gi % 4);

        logic signed [CW-1:0] w_cy;
        logic signed [CW-1:0] w_cx;
        logic signed [CW-1:0] w_my;
        logic signed [CW-1:0] w_mx;
        logic                 w_c_xok;
        logic                 w_c_ybot;
        logic                 w_c_above;
        logic                 w_c_in;
        logic [CELL_W-1:0]    w_c_cell;

        assign w_cy      = sext(chk_t.coordinate.y) + PR;
        assign w_cx      = sext(chk_t.coordinate.x) + PC;
        assign w_c_xok   = !w_cx[CW-1] && (w_cx < W_S);
        assign w_c_ybot  = (w_cy < H_S);
        assign w_c_above = w_cy[CW-1];
        assign w_c_in    = w_c_xok && w_c_ybot && !w_c_above;
        assign w_c_cell  = w_c_in ? chk_f[w_cy[RW-1:0]][w_cx[XW-1:0]] : '1;

`ifdef FIELD_SPAWN_ABOVE_EN
        assign w_chk_bad[gi] = w_chk_mask[15-gi] &&
                               (!w_c_xok || !w_c_ybot || (w_c_cell != '1));
`else
        assign w_chk_bad[gi] = w_chk_mask[15-gi] &&
                               (!w_c_xok || !w_c_ybot || w_c_above || (w_c_cell != '1));
`endif

        assign w_my = sext(mrg_t.coordinate.y) + PR;
        assign w_mx = sext(mrg_t.coordinate.x) + PC;
        assign w_mrg_hit[gi] = w_mrg_mask[15-gi] &&
                               !w_mx[CW-1] && (w_mx < W_S) &&
                               !w_my[CW-1] && (w_my < H_S);
        assign w_mrg_row[gi] = w_my[RW-1:0];
        assign w_mrg_col[gi] = w_mx[XW-1:0];
    end

    // The piece index under test plays no part in the fit decision.
    assign w_idx_seen = |{chk_t.idx, 1'b1};
    assign is_valid   = w_idx_seen && (w_chk_bad == 16'h0000);

    always_comb begin
        mrg_f_out = mrg_f;
        for (int i = 0; i < 16; i++) begin
            if (w_mrg_hit[i]) begin
                mrg_f_out[w_mrg_row[i]][w_mrg_col[i]] = CELL_W'(mrg_t.idx);
            end
        end
    end

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SCAN = 2'd1,
        ST_DONE = 2'd2
    } clean_state_t;

    clean_state_t        r_state;
    clean_state_t        w_state_next;
    field_t              r_field;
    field_t              w_field_next;
    field_t              w_shifted;
    logic [RW-1:0]       r_row;
    logic [RW-1:0]       w_row_next;
    logic [2:0]          r_count;
    logic [2:0]          w_count_next;
    row_t                w_row_data;
    logic [FIELD_W-1:0]  w_col_filled;
    logic                w_row_full;

    assign w_row_data = r_field[r_row];

    for (genvar gi = 0; gi < FIELD_W; gi++) begin : g_col
        assign w_col_filled[gi] = (w_row_data[gi] != '1);
    end
    assign w_row_full = &w_col_filled;

    // Gravity: every row at or above the pointer takes the row above it; row 0 empties.
    for (genvar gi = 0; gi < FIELD_H; gi++) begin : g_shift
        if (gi == 0) begin : g_top
            assign w_shifted[gi] = '1;
        end else begin : g_body
            assign w_shifted[gi] = (RW'(gi) <= r_row) ? r_field[gi-1] : r_field[gi];
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_field_next = r_field;
        w_row_next   = r_row;
        w_count_next = r_count;
        case (r_state)
            ST_IDLE: begin
                if (clean_enable) begin
                    w_field_next = clean_f_in;
                    w_row_next   = RW'(FIELD_H - 1);
                    w_count_next = '0;
                    w_state_next = ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (!clean_enable) begin
                    w_state_next = ST_IDLE;
                end else if (w_row_full) begin
                    w_field_next = w_shifted;
                    w_count_next = (&r_count) ? r_count : r_count + 3'd1;
                end else if (r_row == '0) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_row_next = r_row - RW'(1);
                end
            end
            ST_DONE: begin
                if (!clean_enable) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_field <= '1;
            r_row   <= RW'(FIELD_H - 1);
            r_count <= '0;
        end else begin
            r_state <= w_state_next;
            r_field <= w_field_next;
            r_row   <= w_row_next;
            r_count <= w_count_next;
        end
    end

    assign clean_f_out   = r_field;
    assign lines_cleared = r_count;
    assign clean_done    = (r_state == ST_DONE);

endmodule

// File: tb/tb_tetris_field_logic.sv
// Directed bench for tetris_field_logic: expectations queued on a scoreboard, checked on output.
module tb_tetris_field_logic;
    import tetris_pkg::*;

    localparam int W  = 10;
    localparam int H  = 22;
    localparam int CB = 3;
    localparam int FB = W * H * CB;

    typedef logic [H-1:0][W-1:0][CB-1:0] fld_t;

    logic          clk = 1'b0;
    logic          rst;
    tetromino_ctrl chk_t;
    tetromino_ctrl mrg_t;
    fld_t          chk_f;
    fld_t          mrg_f;
    fld_t          mrg_f_out;
    fld_t          clean_f_in;
    fld_t          clean_f_out;
    logic          is_valid;
    logic          clean_enable;
    logic          clean_done;
    logic [2:0]    lines_cleared;

    always #5 clk = ~clk;

    tetris_field_logic #(.FIELD_W(W), .FIELD_H(H), .CELL_W(CB)) dut (
        .clk           (clk),
        .rst           (rst),
        .chk_t         (chk_t),
        .chk_f         (chk_f),
        .is_valid      (is_valid),
        .mrg_t         (mrg_t),
        .mrg_f         (mrg_f),
        .mrg_f_out     (mrg_f_out),
        .clean_enable  (clean_enable),
        .clean_f_in    (clean_f_in),
        .clean_f_out   (clean_f_out),
        .lines_cleared (lines_cleared),
        .clean_done    (clean_done)
    );

    typedef struct {
        string          tag;
        logic [FB-1:0]  val;
    } sb_t;

    sb_t sb_q[$];
    int  checks = 0;
    int  errors = 0;

    task automatic push(input string tag, input logic [FB-1:0] val);
        sb_t e;
        e.tag = tag;
        e.val = val;
        sb_q.push_back(e);
    endtask

    task automatic pop(input logic [FB-1:0] obs);
        sb_t e;
        checks++;
        if (sb_q.size() == 0) begin
            errors++;
            $error("FAIL scoreboard_empty: observed=%0h required=none", obs);
            return;
        end
        e = sb_q.pop_front();
        assert (obs === e.val) else begin
            errors++;
            $error("FAIL %0s: observed=%0h required=%0h", e.tag, obs, e.val);
        end
        $display("[%0t] check %0s observed=%0h", $time, e.tag, obs);
    endtask

    task automatic set_chk(input int x, input int y, input logic [1:0] rot);
        chk_t.coordinate.x = 8'(x);
        chk_t.coordinate.y = 8'(y);
        chk_t.rotation     = rot;
    endtask

    task automatic run_clean(input fld_t f, output int edges);
        @(negedge clk);
        clean_f_in   = f;
        clean_enable = 1'b1;
        edges        = -1;
        for (int n = 1; n <= 200; n++) begin
            @(posedge clk);
            #1;
            if (clean_done) begin
                edges = n;
                break;
            end
        end
    endtask

    task automatic drop_enable();
        @(negedge clk);
        clean_enable = 1'b0;
        @(posedge clk);
        #1;
    endtask

    function automatic fld_t full_rows(input int lo, input int hi);
        fld_t f;
        f = '1;
        for (int r = lo; r <= hi; r++)
            for (int c = 0; c < W; c++)
                f[r][c] = TETROMINO_I_IDX;
        return f;
    endfunction

    initial begin
        fld_t f;
        fld_t e;
        int   edges;

        rst          = 1'b1;
        clean_enable = 1'b0;
        clean_f_in   = '1;
        chk_f        = '1;
        mrg_f        = '1;
        chk_t        = '0;
        mrg_t        = '0;
        chk_t.idx    = TETROMINO_T_IDX;
        chk_t.tetromino.data[0] = 16'h4E00;
        chk_t.tetromino.data[1] = 16'h4640;
        mrg_t.idx    = TETROMINO_T_IDX;
        mrg_t.tetromino.data[0] = 16'h4E00;

        #1;
        push("rst_done", '0);          pop(FB'(clean_done));
        push("rst_lines", '0);         pop(FB'(lines_cleared));
        push("rst_field", {FB{1'b1}}); pop(clean_f_out);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        set_chk(5, 5, 2'd0);
        push("chk_t_5_5", FB'(1'b1)); #1; pop(FB'(is_valid));
        set_chk(-2, 5, 2'd0);
        push("chk_left_x-2", FB'(1'b0)); #1; pop(FB'(is_valid));
        chk_f[5][6] = TETROMINO_I_IDX;
        set_chk(5, 5, 2'd0);
        push("chk_collide", FB'(1'b0)); #1; pop(FB'(is_valid));
        chk_f = '1;
        set_chk(7, 5, 2'd0);
        push("chk_right_x7", FB'(1'b1)); #1; pop(FB'(is_valid));
        set_chk(8, 5, 2'd0);
        push("chk_right_x8", FB'(1'b0)); #1; pop(FB'(is_valid));
        set_chk(5, 20, 2'd0);
        push("chk_bottom_y20", FB'(1'b1)); #1; pop(FB'(is_valid));
        set_chk(5, 21, 2'd0);
        push("chk_bottom_y21", FB'(1'b0)); #1; pop(FB'(is_valid));
        set_chk(7, 5, 2'd1);
        push("chk_rot1_x7", FB'(1'b1)); #1; pop(FB'(is_valid));
        set_chk(8, 5, 2'd1);
        push("chk_rot1_x8", FB'(1'b0)); #1; pop(FB'(is_valid));
        set_chk(5, -1, 2'd0);
`ifdef FIELD_SPAWN_ABOVE_EN
        push("chk_above_y-1", FB'(1'b1));
`else
        push("chk_above_y-1", FB'(1'b0));
`endif
        #1; pop(FB'(is_valid));

        mrg_t.coordinate.x = 8'd0;
        mrg_t.coordinate.y = 8'd0;
        e = '1;
        e[0][1] = TETROMINO_T_IDX;
        e[1][0] = TETROMINO_T_IDX;
        e[1][1] = TETROMINO_T_IDX;
        e[1][2] = TETROMINO_T_IDX;
        push("mrg_origin", e); #1; pop(mrg_f_out);

        mrg_f = '1;
        mrg_f[21][0] = TETROMINO_I_IDX;
        mrg_t.coordinate.x = 8'd8;
        e = mrg_f;
        e[0][9] = TETROMINO_T_IDX;
        e[1][8] = TETROMINO_T_IDX;
        e[1][9] = TETROMINO_T_IDX;
        push("mrg_clip_right", e); #1; pop(mrg_f_out);

        f = full_rows(20, 20);
        f[19][0] = TETROMINO_O_IDX;
        e = '1;
        e[20][0] = TETROMINO_O_IDX;
        push("clr1_edges", FB'(24));
        push("clr1_lines", FB'(3'd1));
        push("clr1_field", e);
        run_clean(f, edges);
        pop(FB'(edges));
        pop(FB'(lines_cleared));
        pop(clean_f_out);
        repeat (3) @(posedge clk);
        #1;
        push("clr1_done_hold", FB'(1'b1));  pop(FB'(clean_done));
        push("clr1_lines_hold", FB'(3'd1)); pop(FB'(lines_cleared));
        push("clr1_done_drop", FB'(1'b0));
        drop_enable();
        pop(FB'(clean_done));

        push("clr4_edges", FB'(27));
        push("clr4_lines", FB'(3'd4));
        push("clr4_field", {FB{1'b1}});
        run_clean(full_rows(18, 21), edges);
        pop(FB'(edges));
        pop(FB'(lines_cleared));
        pop(clean_f_out);
        push("clr4_done_drop", FB'(1'b0));
        drop_enable();
        pop(FB'(clean_done));

        push("clr8_edges", FB'(31));
        push("clr8_lines_sat", FB'(3'd7));
        push("clr8_field", {FB{1'b1}});
        run_clean(full_rows(14, 21), edges);
        pop(FB'(edges));
        pop(FB'(lines_cleared));
        pop(clean_f_out);
        drop_enable();

        f = full_rows(21, 21);
        f[10][3] = TETROMINO_S_IDX;
        e = '1;
        e[11][3] = TETROMINO_S_IDX;
        @(negedge clk);
        clean_f_in   = f;
        clean_enable = 1'b1;
        repeat (3) @(posedge clk);
        push("abort_done", FB'(1'b0));
        push("abort_lines", FB'(3'd1));
        push("abort_field", e);
        drop_enable();
        repeat (3) @(posedge clk);
        #1;
        pop(FB'(clean_done));
        pop(FB'(lines_cleared));
        pop(clean_f_out);

        @(negedge clk);
        clean_f_in   = f;
        clean_enable = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        push("scan_lines_pre_rst", FB'(3'd1)); pop(FB'(lines_cleared));
        #1;
        rst = 1'b1;
        #1;
        push("rst_scan_done", FB'(1'b0));       pop(FB'(clean_done));
        push("rst_scan_lines", FB'(3'd0));      pop(FB'(lines_cleared));
        push("rst_scan_field", {FB{1'b1}});     pop(clean_f_out);
        clean_enable = 1'b0;
        @(negedge clk);
        rst = 1'b0;

        push("clr0_edges", FB'(23));
        push("clr0_lines", FB'(3'd0));
        run_clean('1, edges);
        pop(FB'(edges));
        pop(FB'(lines_cleared));
        drop_enable();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
